// File: rtl/lec_scan_sched_pkg.sv
// Shared types and sizing helpers for the chunked OR-scan sequencer.
package lec_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-wide slices needed to cover a WIDTH-bit vector.
  function automatic int unsigned calc_nchunk(input int unsigned w, input int unsigned c);
    return (w + c - 1) / c;
  endfunction

  // Counter width able to index n distinct values (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lec_scan_sched_chunk_or.sv
// Masked OR-reduction of one chunk; only the low nvalid bits take part.
module lec_chunk_or
  import lec_scan_pkg::*;
#(
  parameter int unsigned CHUNK = 64,
  localparam int unsigned CW = idx_width(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic [CW-1:0]    nvalid,
  output logic             red_c
);

  logic [CHUNK-1:0] mask;

  // Build the valid-bit mask and reduce the surviving bits.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (i < 32'(nvalid)) mask[i] = 1'b1;
    end
    red_c = |(chunk & mask);
  end

endmodule

// File: rtl/lec_scan_sched.sv
// Captures a wide vector on start and folds its chunk OR-reductions into
// NOUT sticky lanes, one chunk per cycle through a shared reduction unit.
module lec_scan_sched
  import lec_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 1085,
  parameter int unsigned CHUNK = 64,
  parameter int unsigned NOUT  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_vec,
  output logic             busy,
  output logic             done,
  output logic [NOUT-1:0]  result
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned PADW   = NCHUNK * CHUNK;
  localparam int unsigned IW     = idx_width(NCHUNK);
  localparam int unsigned LW     = idx_width(NOUT);
  localparam int unsigned CW     = idx_width(CHUNK + 1);
  localparam int unsigned LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    idx;
  logic [LW-1:0]    lane;
  logic [WIDTH-1:0] cap;
  logic [NOUT-1:0]  acc;
  logic [PADW-1:0]  cap_pad;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    nvalid;
  logic             red_c;
  logic             last_c;
  logic             load_c;
  logic             step_c;

  assign last_c = (idx == IW'(NCHUNK - 1));

  // Select the current chunk; padding above WIDTH reads as zero.
  always_comb begin
    cap_pad              = '0;
    cap_pad[WIDTH-1:0]   = cap;
    chunk                = cap_pad[32'(idx) * CHUNK +: CHUNK];
    nvalid               = last_c ? CW'(LASTW) : CW'(CHUNK);
  end

  lec_chunk_or #(
    .CHUNK (CHUNK)
  ) u_chunk_or (
    .chunk  (chunk),
    .nvalid (nvalid),
    .red_c  (red_c)
  );

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        step_c = 1'b1;
        if (last_c) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered busy/done decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state == DONE);
    end
  end

  // Capture, chunk/lane counters, sticky accumulator and result publish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap    <= '0;
      acc    <= '0;
      idx    <= '0;
      lane   <= '0;
      result <= '0;
    end else begin
      if (load_c) begin
        cap  <= in_vec;
        acc  <= '0;
        idx  <= '0;
        lane <= '0;
      end else if (step_c) begin
        acc[lane] <= acc[lane] | red_c;
        idx       <= last_c ? '0 : idx + IW'(1);
        lane      <= (lane == LW'(NOUT - 1)) ? '0 : lane + LW'(1);
      end
      if (state == DONE) result <= acc;
    end
  end

endmodule

// File: tb/tb_lec_scan_sched.sv
// Randomized and directed checks of lec_scan_sched against a bit-level model.
module tb_lec_scan_sched;

  localparam int unsigned W  = 1085;
  localparam int unsigned C  = 64;
  localparam int unsigned N  = 9;
  localparam int          LAT = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in_vec;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int checks = 0;
  int passes = 0;

  lec_scan_sched #(.WIDTH(W), .CHUNK(C), .NOUT(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in_vec (in_vec),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Expected flags: any set input bit i lights lane (i / C) mod N.
  function automatic logic [N-1:0] model(input logic [W-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++)
      if (v[i]) r[(i / int'(C)) % int'(N)] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_sparse();
    logic [W-1:0] v;
    int n;
    v = '0;
    n = int'($urandom_range(0, 4));
    for (int k = 0; k < n; k++) v[$urandom_range(0, W - 1)] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_dense();
    logic [W-1:0] v;
    for (int i = 0; i < int'(W); i++) v[i] = ($urandom_range(0, 99) < 2);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full scan with stray starts while busy and in the DONE cycle.
  task automatic do_scan(input logic [W-1:0] v, input string tag);
    int cyc;
    int busy_cnt;
    bit got;
    logic [N-1:0] exp;
    exp = model(v);
    @(negedge clk);
    in_vec = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_vec   = rand_dense();
    busy_cnt = busy ? 1 : 0;
    cyc      = 0;
    got      = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        cyc = k;
        start = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (k == 3) begin start = 1'b1; in_vec = ~v; end
        if (k == 4) begin start = 1'b0; in_vec = rand_dense(); end
        if (k == 17) start = 1'b1;
      end
    end
    start = 1'b0;
    check($sformatf("%s_done_seen", tag), 32'(got), 32'd1);
    check($sformatf("%s_latency", tag), 32'(cyc), 32'(LAT));
    check($sformatf("%s_busy_cycles", tag), 32'(busy_cnt), 32'(LAT));
    check($sformatf("%s_result", tag), 32'(result), 32'(exp));
    @(posedge clk);
    #1;
    check($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    check($sformatf("%s_idle_after", tag), 32'(busy), 32'd0);
    check($sformatf("%s_result_hold", tag), 32'(result), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] q[$];
    int dcnt;

    rst    = 1'b1;
    start  = 1'b0;
    in_vec = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed lane-mapping and boundary cases.
    do_scan('0, "zero");
    v = '0; v[0] = 1'b1;    do_scan(v, "bit0");
    v = '0; v[575] = 1'b1;  do_scan(v, "bit575");
    v = '0; v[1084] = 1'b1; do_scan(v, "bit1084");
    v = '0; v[640] = 1'b1;  do_scan(v, "bit640");
    do_scan('1, "ones");
    do_scan('0, "zero_after_ones");

    // Random vectors.
    for (int r = 0; r < 6; r++) begin
      v = (r % 2 == 0) ? rand_sparse() : rand_dense();
      do_scan(v, $sformatf("rand%0d", r));
    end

    // start held high: accepts every 19 cycles, each on its own vector.
    @(negedge clk);
    start = 1'b1;
    for (int t = 0; t < 57; t++) begin
      if (t > 0) @(negedge clk);
      v = rand_dense();
      in_vec = v;
      if (t % 19 == 0) q.push_back(v);
      @(posedge clk);
      #1;
      check($sformatf("hold_done_t%0d", t), 32'(done), 32'(t % 19 == 18));
      if (t % 19 == 18 && q.size() > 0)
        check($sformatf("hold_result_t%0d", t), 32'(result), 32'(model(q.pop_front())));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_stopped", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a scan.
    do_scan('1, "pre_rst");
    @(negedge clk);
    in_vec = rand_dense();
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    check("arst_no_done", 32'(dcnt), 32'd0);
    v = rand_dense();
    do_scan(v, "post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lec_scan_sched.md
Name: lec_scan_sched

Overview:
- Sequencer that time-shares one CHUNK-bit OR-reduction unit across a wide primary-input vector of a LEC test top.
- Default input width is 1085 bits, matching the i1..i1085 style of the test cases.
- Captures the vector on a start request and scans it chunk by chunk.
- Accumulates sticky per-output flags into NOUT result bits (default 9, matching o1..o9).
- Sits between the stimulus driver and the compared outputs. Provides a sequential, non-trivial reference for equivalence cases whose outputs are constant-0 unless any input is set.

Parameters:
- WIDTH, 1085, width of captured input vector (in_vec[0] corresponds to i1).
- CHUNK, 64, bits reduced per cycle by the shared reduction unit.
- NOUT, 9, number of result lanes (o1..o9).
- NCHUNK, ceil(WIDTH/CHUNK) = 17, derived localparam (not overridable).

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, scan request; honoured only in IDLE.
- in_vec, input, WIDTH, vector sampled on the accepted start cycle.
- busy, output, 1, high in SCAN and DONE states.
- done, output, 1, one-cycle pulse when result is updated.
- result, output, NOUT, per-lane flags (bit k drives o(k+1)); holds until next done.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE, busy=0, done=0, result=0.
  - Chunk index=0, accumulator=0, capture register=0.
  - Reset mid-scan abandons the scan; no done is produced.
- States: IDLE, SCAN, DONE.
- IDLE, start=1: capture in_vec, clear accumulator, idx=0, go to SCAN. start=0: stay.
- SCAN, each cycle:
  - red = OR of capture[idx*CHUNK +: CHUNK].
  - Bits at or beyond WIDTH are treated as 0 (the last chunk is 61 bits with defaults).
  - acc[idx mod NOUT] |= red.
  - idx==NCHUNK-1: go to DONE; else idx+1.
  - Lane mapping with defaults: lane k gets chunks k and k+9 for k=0..7; lane 8 gets chunk 8 only; chunk 16 maps to lane 7.
- DONE (1 cycle): result<=acc, done=1, then IDLE.
- Latency: start accepted at edge E0; done and new result are visible after edge E0+NCHUNK+1 (18 cycles with defaults).
- start while busy: ignored, not queued. in_vec changes after capture have no effect.
- start in the DONE cycle: ignored. start in the first IDLE cycle after DONE: accepted (back-to-back spacing NCHUNK+2 cycles).
- idx mod NOUT: use a separate lane counter wrapping NOUT-1 to 0, not a divider.
- busy is a registered state decode; done is a registered state decode (no combinational path from start).

Decomposition:
- Package lec_scan_pkg:
  - State enum (IDLE/SCAN/DONE).
  - Functions computing NCHUNK and index widths ($clog2(NCHUNK), $clog2(NOUT)).
- One sub-module: lec_chunk_or.
  - Combinational CHUNK-bit masked OR-reduction.
  - Takes the chunk and a valid-bit count for the final partial chunk.
- The top holds the FSM, counters, capture register and accumulator.

Test Plan:
1. in_vec=0, start pulse -> done after exactly 18 cycles, result=9'h000, busy high for 18 cycles.
2. in_vec[0]=1 only -> result=9'h001; in_vec[575]=1 only (chunk 8) -> result=9'h100.
3. in_vec[1084]=1 only (last partial chunk 16) -> result=9'h080; in_vec[640]=1 (chunk 10) -> result=9'h002.
4. All-ones in_vec -> result=9'h1FF. Then start with in_vec=0 -> result returns to 9'h000 (no stale stickiness across scans).
5. start held high continuously, in_vec toggling every cycle -> one scan per 19 cycles. Each result reflects only the vector present at its accepting edge.
6. rst asserted asynchronously at scan cycle 5 -> busy, done and result go to 0 immediately. No done follows. The next start completes normally in 18 cycles.
